time_set_module: RTL and testbench

Button-driven editor that builds the packed set-time word shown on the display and commits it either to the running clock or to the stored alarm. It drives the display's source-select, cursor and blink-group inputs: the display consumes ST/S/CW/CW1, and this block produces them. Button inputs are already synchronized, level-high while pressed.

---
 rtl/time_set_pkg.sv | 47 ++++
 rtl/time_set_module_button_edge.sv | 71 +++++++
 rtl/time_set_module.sv | 163 ++++++++++++++++
 tb/tb_time_set_module.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared definitions for the set-time editor.
// Contents: editor state enum, packed time-word field positions and widths, the reset time word,
// per-field legal ranges, and a wrap-around step helper used for Up/Down edits.
package time_set_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEDay,
    StEHour,
    StEMt,
    StEMu
  } state_e;

  // Packed time word: [15] PM, [14:12] day, [11:8] hour, [7:4] minute tens, [3:0] minute units.
  localparam int unsigned PmBit   = 15;
  localparam int unsigned DayLsb  = 12;
  localparam int unsigned DayW    = 3;
  localparam int unsigned HourLsb = 8;
  localparam int unsigned HourW   = 4;
  localparam int unsigned MtLsb   = 4;
  localparam int unsigned MtW     = 4;
  localparam int unsigned MuLsb   = 0;
  localparam int unsigned MuW     = 4;

  // Day 0, 12:00, AM.
  localparam logic [15:0] RESET_TIME = 16'h0C00;

  localparam logic [3:0] DayMin  = 4'd0;
  localparam logic [3:0] DayMax  = 4'd6;
  localparam logic [3:0] HourMin = 4'd1;
  localparam logic [3:0] HourMax = 4'd12;
  localparam logic [3:0] MtMin   = 4'd0;
  localparam logic [3:0] MtMax   = 4'd5;
  localparam logic [3:0] MuMin   = 4'd0;
  localparam logic [3:0] MuMax   = 4'd9;

  // One Up/Down step inside [lo, hi] with wrap. An out-of-range value jumps straight to the wrap
  // target (lo for Up, hi for Down).
  function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] lo,
                                           input logic [3:0] hi, input logic up);
    if (up) begin
      return ((v >= hi) || (v < lo)) ? lo : v + 4'd1;
    end
    return ((v <= lo) || (v > hi)) ? hi : v - 4'd1;
  endfunction

endpackage

// File: rtl/time_set_module_button_edge.sv
// Rising-edge detector for one synchronized, level-high button.
// Optional auto-repeat when built with AUTO_REPEAT_EN: a button instantiated with RepeatEn = 1
// that stays held HOLD_CYCLES after its rising edge emits an extra pulse, then one more every
// REPEAT_CYCLES until release.
// Ports: clk_i clock, rst_i async active-high reset, btn_i button level, pulse_o event pulse.
module button_edge #(
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100,
  parameter bit          RepeatEn      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  // The reload trick in the repeat counter needs 1 <= REPEAT_CYCLES <= HOLD_CYCLES.
  if (RepeatEn && ((HOLD_CYCLES == 0) || (REPEAT_CYCLES == 0) ||
                   (REPEAT_CYCLES > HOLD_CYCLES))) begin : g_bad_cfg
    $error("button_edge: need 1 <= REPEAT_CYCLES <= HOLD_CYCLES");
  end

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= btn_i;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 2);
  localparam logic [CntW-1:0] CntHold   = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntReload = CntW'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  // cnt_q tracks how many cycles the button has been held since its rising edge. On reaching the
  // hold point it reloads so the next hit comes exactly REPEAT_CYCLES later.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rep;

  always_comb begin
    cnt_d = '0;
    rep   = 1'b0;
    if (RepeatEn && btn_i) begin
      if (!prev_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q == CntHold) begin
        rep   = 1'b1;
        cnt_d = CntReload;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_o = (btn_i & ~prev_q) | rep;
`else
  assign pulse_o = btn_i & ~prev_q;
`endif

endmodule

// File: rtl/time_set_module.sv
// Button-driven editor for the packed set-time word.
// Mode/Alm enter clock/alarm edit from idle; Next walks the cursor day -> hour -> min tens ->
// min units; Up/Down step the field under the cursor; Mode commits (Load pulse for the clock,
// AT update for the alarm). An edit with no event for TIMEOUT_CYCLES aborts back to idle.
// Ports: Clk, Clr (async active-high), buttons Mode/Alm/Next/Up/Down, CT/CPM current time;
// outputs ST edit word, AT alarm word, S {edit active, target}, CW cursor, CW1 blink group,
// Load clock-load pulse.
// Build option: AUTO_REPEAT_EN enables held-button auto-repeat on Up/Down.
module time_set_module
  import time_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES    = 500,
  parameter int unsigned REPEAT_CYCLES  = 100
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Mode,
  input  logic        Alm,
  input  logic        Next,
  input  logic        Up,
  input  logic        Down,
  input  logic [14:0] CT,
  input  logic        CPM,
  output logic [15:0] ST,
  output logic [15:0] AT,
  output logic [1:0]  S,
  output logic [1:0]  CW,
  output logic [1:0]  CW1,
  output logic        Load
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic mode_p, alm_p, next_p, up_p, down_p;

  button_edge #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .RepeatEn(1'b0))
    u_mode (.clk_i(Clk), .rst_i(Clr), .btn_i(Mode), .pulse_o(mode_p));
  button_edge #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .RepeatEn(1'b0))
    u_alm (.clk_i(Clk), .rst_i(Clr), .btn_i(Alm), .pulse_o(alm_p));
  button_edge #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .RepeatEn(1'b0))
    u_next (.clk_i(Clk), .rst_i(Clr), .btn_i(Next), .pulse_o(next_p));
  button_edge #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .RepeatEn(1'b1))
    u_up (.clk_i(Clk), .rst_i(Clr), .btn_i(Up), .pulse_o(up_p));
  button_edge #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .RepeatEn(1'b1))
    u_down (.clk_i(Clk), .rst_i(Clr), .btn_i(Down), .pulse_o(down_p));

  state_e          state_q, state_d;
  logic [15:0]     st_q, st_d, at_q, at_d;
  logic            target_q, target_d, load_q, load_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            step_ev, step_up;
  logic [3:0]      fld, fld_new;

  // Up and Down together cancel out.
  assign step_ev = up_p ^ down_p;
  assign step_up = up_p;

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    at_d     = at_q;
    target_d = target_q;
    load_d   = 1'b0;
    tmo_d    = '0;
    fld      = '0;
    fld_new  = '0;
    if (state_q == StIdle) begin
      if (mode_p) begin
        st_d     = {CPM, CT};
        target_d = 1'b0;
        state_d  = StEDay;
      end else if (alm_p) begin
        st_d     = at_q;
        target_d = 1'b1;
        state_d  = StEDay;
      end
    end else if (mode_p) begin
      if (target_q) begin
        at_d = st_q;
      end else begin
        load_d = 1'b1;
      end
      target_d = 1'b0;
      state_d  = StIdle;
    end else if (next_p) begin
      unique case (state_q)
        StEDay:  state_d = StEHour;
        StEHour: state_d = StEMt;
        StEMt:   state_d = StEMu;
        default: state_d = StEDay;
      endcase
    end else if (step_ev) begin
      unique case (state_q)
        StEDay: begin
          fld     = {1'b0, st_q[DayLsb +: DayW]};
          fld_new = wrap_step(fld, DayMin, DayMax, step_up);
          st_d[DayLsb +: DayW] = fld_new[DayW-1:0];
        end
        StEHour: begin
          fld     = st_q[HourLsb +: HourW];
          fld_new = wrap_step(fld, HourMin, HourMax, step_up);
          st_d[HourLsb +: HourW] = fld_new;
          // Crossing 11 <-> 12 flips AM/PM; the 12 <-> 1 wrap does not.
          if ((step_up && (fld == HourMax - 4'd1)) || (!step_up && (fld == HourMax))) begin
            st_d[PmBit] = ~st_q[PmBit];
          end
        end
        StEMt: begin
          fld     = st_q[MtLsb +: MtW];
          fld_new = wrap_step(fld, MtMin, MtMax, step_up);
          st_d[MtLsb +: MtW] = fld_new;
        end
        default: begin
          fld     = st_q[MuLsb +: MuW];
          fld_new = wrap_step(fld, MuMin, MuMax, step_up);
          st_d[MuLsb +: MuW] = fld_new;
        end
      endcase
    end else if (tmo_q == TmoLast) begin
      target_d = 1'b0;
      state_d  = StIdle;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q  <= StIdle;
      st_q     <= RESET_TIME;
      at_q     <= RESET_TIME;
      target_q <= 1'b0;
      load_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      at_q     <= at_d;
      target_q <= target_d;
      load_q   <= load_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    ST   = st_q;
    AT   = at_q;
    Load = load_q;
    S    = {state_q != StIdle, target_q};
    CW   = 2'd0;
    CW1  = 2'b00;
    unique case (state_q)
      StEDay:  begin CW = 2'd0; CW1 = 2'b01; end
      StEHour: begin CW = 2'd1; CW1 = 2'b10; end
      StEMt:   begin CW = 2'd2; CW1 = 2'b11; end
      StEMu:   begin CW = 2'd3; CW1 = 2'b11; end
      default: begin CW = 2'd0; CW1 = 2'b00; end
    endcase
  end

endmodule

// File: tb/tb_time_set_module.sv
// Self-checking bench for time_set_module: directed scenarios plus a randomized run, all checked
// every cycle against a field-level behavioural model of the editor.
module tb_time_set_module;

  localparam int unsigned Timeout = 40;
  localparam int unsigned Hold    = 12;
  localparam int unsigned Rep     = 4;

  logic        Clk, Clr, Mode, Alm, Next, Up, Down, CPM;
  logic [14:0] CT;
  logic [15:0] ST, AT;
  logic [1:0]  S, CW, CW1;
  logic        Load;

  time_set_module #(
    .TIMEOUT_CYCLES(Timeout),
    .HOLD_CYCLES   (Hold),
    .REPEAT_CYCLES (Rep)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .Mode(Mode),
    .Alm (Alm),
    .Next(Next),
    .Up  (Up),
    .Down(Down),
    .CT  (CT),
    .CPM (CPM),
    .ST  (ST),
    .AT  (AT),
    .S   (S),
    .CW  (CW),
    .CW1 (CW1),
    .Load(Load)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [15:0] m_st, m_at;
  bit          m_edit, m_tgt, m_load;
  int          m_fld, m_idle, up_len, dn_len;
  bit          pv_md, pv_al, pv_nx, pv_up, pv_dn;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 16'h0C00; m_at = 16'h0C00;
    m_edit = 0; m_tgt = 0; m_load = 0;
    m_fld = 0; m_idle = 0; up_len = 0; dn_len = 0;
    pv_md = 0; pv_al = 0; pv_nx = 0; pv_up = 0; pv_dn = 0;
  endtask

  task automatic apply_field(input bit up);
    int v;
    case (m_fld)
      0: begin
        v = int'(m_st[14:12]);
        if (v > 6) v = up ? 0 : 6;
        else v = up ? (v + 1) % 7 : (v + 6) % 7;
        m_st[14:12] = 3'(v);
      end
      1: begin
        v = int'(m_st[11:8]);
        if (v < 1 || v > 12) v = up ? 1 : 12;
        else begin
          if ((up && v == 11) || (!up && v == 12)) m_st[15] = ~m_st[15];
          v = up ? (v % 12) + 1 : ((v + 10) % 12) + 1;
        end
        m_st[11:8] = 4'(v);
      end
      2: begin
        v = int'(m_st[7:4]);
        if (v > 5) v = up ? 0 : 5;
        else v = up ? (v + 1) % 6 : (v + 5) % 6;
        m_st[7:4] = 4'(v);
      end
      default: begin
        v = int'(m_st[3:0]);
        if (v > 9) v = up ? 0 : 9;
        else v = up ? (v + 1) % 10 : (v + 9) % 10;
        m_st[3:0] = 4'(v);
      end
    endcase
  endtask

  // Advance the model by one clock with the given button levels and current CT/CPM.
  task automatic model_cycle(input bit md, input bit al, input bit nx, input bit up, input bit dn);
    bit mp, ap, np, ue, de;
    mp = md && !pv_md;
    ap = al && !pv_al;
    np = nx && !pv_nx;
    ue = up && !pv_up;
    de = dn && !pv_dn;
    if (up && pv_up) up_len++; else up_len = 0;
    if (dn && pv_dn) dn_len++; else dn_len = 0;
`ifdef AUTO_REPEAT_EN
    if (up_len >= Hold && (up_len - Hold) % Rep == 0) ue = 1;
    if (dn_len >= Hold && (dn_len - Hold) % Rep == 0) de = 1;
`endif
    pv_md = md; pv_al = al; pv_nx = nx; pv_up = up; pv_dn = dn;
    m_load = 0;
    if (!m_edit) begin
      if (mp) begin
        m_st = {CPM, CT}; m_tgt = 0; m_edit = 1; m_fld = 0; m_idle = 0;
      end else if (ap) begin
        m_st = m_at; m_tgt = 1; m_edit = 1; m_fld = 0; m_idle = 0;
      end
    end else if (mp) begin
      if (m_tgt) m_at = m_st;
      else m_load = 1;
      m_edit = 0; m_tgt = 0; m_idle = 0;
    end else if (np) begin
      m_fld = (m_fld + 1) % 4; m_idle = 0;
    end else if (ue != de) begin
      apply_field(ue); m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == Timeout) begin
        m_edit = 0; m_tgt = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check_all();
    int cw1;
    cw1 = !m_edit ? 0 : (m_fld == 0 ? 1 : (m_fld == 1 ? 2 : 3));
    chk("ST", ST, m_st);
    chk("AT", AT, m_at);
    chk("S", 16'(S), 16'({m_edit, m_tgt}));
    chk("CW", 16'(CW), 16'(m_edit ? m_fld : 0));
    chk("CW1", 16'(CW1), 16'(cw1));
    chk("Load", 16'(Load), 16'(m_load));
  endtask

  task automatic cyc(input bit md, input bit al, input bit nx, input bit up, input bit dn);
    Mode = md; Alm = al; Next = nx; Up = up; Down = dn;
    model_cycle(md, al, nx, up, dn);
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic press(input bit md, input bit al, input bit nx, input bit up, input bit dn);
    cyc(md, al, nx, up, dn);
    cyc(0, 0, 0, 0, 0);
  endtask

  logic [15:0] saved;
  int          n_inc;

  initial begin
    Clr = 1'b1; Mode = 0; Alm = 0; Next = 0; Up = 0; Down = 0;
    CT = 15'h3B59; CPM = 1'b0;
    #12;
    model_reset();
    check_all();
    chk("reset_ST", ST, 16'h0C00);
    Clr = 1'b0;

    // Clock edit: Mode, Next, Up (11 -> 12 sets PM), Mode commits with a Load pulse.
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("commit_load", 16'(Load), 16'd1);
    chk("commit_ST", ST, 16'hBC59);
    cyc(0, 0, 0, 0, 0);
    chk("load_drop", 16'(Load), 16'd0);

    // Alarm edit: day round trip, units 0 -> 9, commit to AT.
    press(0, 1, 0, 0, 0);
    chk("alm_S", 16'(S), 16'd3);
    for (int i = 0; i < 7; i++) press(0, 0, 0, 1, 0);
    chk("day_roundtrip", ST, 16'h0C00);
    for (int i = 0; i < 3; i++) press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    chk("units_wrap_down", ST, 16'h0C09);
    press(1, 0, 0, 0, 0);
    chk("alm_commit_AT", AT, 16'h0C09);

    // Timeout.
    press(1, 0, 0, 0, 0);
    for (int i = 0; i < int'(Timeout) - 2; i++) cyc(0, 0, 0, 0, 0);
    chk("pre_timeout_S", 16'(S), 16'd2);
    cyc(0, 0, 0, 0, 0);
    chk("timeout_S", 16'(S), 16'd0);
    chk("timeout_AT", AT, 16'h0C09);

    // Up+Down cancel; Next+Up only advances.
    CT = 15'h2759; CPM = 1'b1;
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    saved = ST;
    press(0, 0, 0, 1, 1);
    chk("updown_cancel", ST, saved);
    press(0, 0, 1, 1, 0);
    chk("next_up_cw", 16'(CW), 16'd2);
    chk("next_up_st", ST, saved);

    // Held Up in minute units.
    press(0, 0, 1, 0, 0);
`ifdef AUTO_REPEAT_EN
    n_inc = 4;
`else
    n_inc = 1;
`endif
    saved = ST;
    for (int i = 0; i < int'(Hold + 3 * Rep); i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hold_up_units", 16'(ST[3:0]), 16'((int'(saved[3:0]) + n_inc) % 10));
    press(1, 0, 0, 0, 0);

    // Randomized run, including out-of-range CT fields.
    for (int i = 0; i < 400; i++) begin
      CT  = 15'($urandom);
      CPM = 1'($urandom);
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Clr mid-cycle right after a clock commit drops the pending Load.
    CT = 15'h1234; CPM = 1'b0;
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pre_clr_load", 16'(Load), 16'd1);
    Mode = 0;
    #3 Clr = 1'b1;
    #1;
    model_reset();
    check_all();
    Clr = 1'b0;
    cyc(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
